valu_wb_fifo: RTL and testbench
===============================

// Module: valu_wb_fifo
// PURPOSE
// - Writeback buffer directly downstream of the vector AND/OR/XOR ALU pipeline; accepts its
//   out_* result bundle every cycle with no backpressure and drains it to the VRF write port
//   over a valid/ready handshake.
// - Absorbs VRF write-port stalls. Raises issue_stall early enough that results already in
//   flight in the ALU pipeline can never overflow the buffer.
// PARAMETERS
// - REQ_DATA_WIDTH  64  result data width; equals the ALU RESP_DATA_WIDTH
// - REQ_ADDR_WIDTH  32  destination address width
// - DEPTH           16  FIFO entries; power of 2, must be >= PIPE_DEPTH+2
// - PIPE_DEPTH       6  ALU in-flight stages, i.e. results issued but not yet delivered
// PORTS
// - clk           in   1   clock; all state updates on the rising edge
// - rst           in   1   synchronous reset, active-high
// - in_valid      in   1   ALU result valid; no ready is returned to the ALU
// - in_vec        in   REQ_DATA_WIDTH  result data
// - in_addr       in   REQ_ADDR_WIDTH  destination address
// - in_mask       in   1   result is a mask-register write
// - in_sca        in   1   result is a scalar/move result
// - in_w_reg      in   1   whole-register write
// - wb_valid      out  1   head entry valid toward the VRF
// - wb_ready      in   1   VRF accepts the head entry this cycle
// - wb_data       out  REQ_DATA_WIDTH  head data
// - wb_addr       out  REQ_ADDR_WIDTH  head address
// - wb_mask       out  1   head mask flag
// - wb_sca        out  1   head sca flag
// - wb_w_reg      out  1   head w_reg flag
// - issue_stall   out  1   upstream must stop issuing new ALU ops
// - count         out  $clog2(DEPTH)+1  current occupancy
// - overflow_err  out  1   sticky; a push was dropped
// BEHAVIOUR
// - Reset: rd_ptr, wr_ptr and count go to 0; wb_valid=0 and overflow_err=0.
//   - issue_stall is 0 after reset, since count=0.
//   - wb_data, wb_addr and all wb_* flags read 0 while empty. Entry storage is not reset.
// - push = in_valid. pop = wb_valid & wb_ready.
// - Entry layout: {addr, vec, mask, sca, w_reg}, stored in a single register array.
// - Latency: an entry pushed in cycle N is visible on wb_* in cycle N+1. There is no bypass.
// - Head outputs are driven from mem[rd_ptr]. They are forced to 0 when count==0.
// - Pointer and count updates:
//   - wr_ptr advances on an accepted push; rd_ptr advances on pop; both wrap modulo DEPTH.
//   - count is count+push_acc-pop.
// - Full (count==DEPTH):
//   - push with pop in the same cycle is accepted; count stays DEPTH.
//   - push without pop is dropped: overflow_err is set to 1, and no pointer or count changes.
// - Empty (count==0): wb_valid=0. wb_ready is ignored. A push makes count=1.
// - Simultaneous push and pop at any non-full occupancy: count is unchanged and both
//   pointers advance.
// - issue_stall = (count >= DEPTH-PIPE_DEPTH-1), a combinational function of the registered count.
//   - The -1 covers the issue-to-stall cycle.
//   - With defaults it asserts at count>=9.
// - wb_* outputs are held stable while wb_valid=1 and wb_ready=0.
// - overflow_err is cleared only by rst.
// - Reset mid-operation: every buffered entry is discarded and the reset values above apply
//   the next cycle.
// - Results drain strictly in arrival order; no flag changes the ordering.
// TESTING
// - Reset, then push {addr=0x10, vec=0xA5A5..A5, mask=1} with wb_ready=0.
//   -> next cycle wb_valid=1, wb_addr=0x10, wb_mask=1, count=1.
// - Push 16 entries with addr 0..15 and wb_ready=0.
//   -> issue_stall rises after the 9th push; count=16; overflow_err=0.
//   -> Then set wb_ready=1: addresses 0..15 drain in order, one per cycle.
// - Fill to 16, then push with wb_ready=1 in the same cycle.
//   -> accepted, count stays 16, overflow_err=0.
//   -> Then push 1 with wb_ready=0: dropped, overflow_err=1 (sticky).
// - Continuous push and pop for 40 cycles with wb_ready=1.
//   -> count holds at 1, and pointers wrap past 15 with no data loss.
// - Load 5 entries, then assert rst for 1 cycle.
//   -> count=0, wb_valid=0, wb_data=0, overflow_err=0.

Source files
------------

// File: rtl/valu_wb_fifo.sv
// Purpose : writeback buffer between the vector logic ALU pipeline and the VRF write port.
// Latency : an entry pushed in cycle N appears on wb_* in cycle N+1 (no bypass path).
// Backpr. : no ready toward the ALU; issue_stall rises while the in-flight results still fit.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/vec/addr/mask/sca/w_reg   ALU result bundle, pushed every valid cycle
//   wb_valid/wb_ready            valid/ready handshake toward the VRF write port
//   wb_data/addr/mask/sca/w_reg  head entry, forced to 0 while the buffer is empty
//   issue_stall                  upstream must stop issuing new ALU ops
//   count                        current occupancy
//   overflow_err                 sticky; a push arrived while full and was dropped
module valu_wb_fifo #(
   parameter int REQ_DATA_WIDTH = 64,
   parameter int REQ_ADDR_WIDTH = 32,
   parameter int DEPTH          = 16,
   parameter int PIPE_DEPTH     = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [REQ_DATA_WIDTH-1:0]   in_vec,
   input  logic [REQ_ADDR_WIDTH-1:0]   in_addr,
   input  logic                        in_mask,
   input  logic                        in_sca,
   input  logic                        in_w_reg,
   output logic                        wb_valid,
   input  logic                        wb_ready,
   output logic [REQ_DATA_WIDTH-1:0]   wb_data,
   output logic [REQ_ADDR_WIDTH-1:0]   wb_addr,
   output logic                        wb_mask,
   output logic                        wb_sca,
   output logic                        wb_w_reg,
   output logic                        issue_stall,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        overflow_err
);

   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   // One extra slot of headroom covers the cycle between issue and seeing the stall.
   localparam int STALL_THR = DEPTH - PIPE_DEPTH - 1;

   typedef struct packed {
      logic [REQ_ADDR_WIDTH-1:0] addr;
      logic [REQ_DATA_WIDTH-1:0] vec;
      logic                      mask;
      logic                      sca;
      logic                      w_reg;
   } entry_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   entry_t             in_entry;
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic               full;
   logic               push;
   logic               pop;
   logic               push_acc;

   assign in_entry = '{addr: in_addr, vec: in_vec, mask: in_mask, sca: in_sca, w_reg: in_w_reg};

   assign full     = (count == CNT_W'(DEPTH));
   assign push     = in_valid;
   assign pop      = wb_valid & wb_ready;
   // When full, a push is only taken if the head leaves in the same cycle.
   assign push_acc = push & (~full | pop);

   assign issue_stall = (count >= CNT_W'(STALL_THR));

   // Head is masked to zero when empty so stale storage never leaks onto wb_*.
   assign wb_valid = (count != '0);
   assign head     = wb_valid ? mem[rd_ptr] : '0;
   assign wb_data  = head.vec;
   assign wb_addr  = head.addr;
   assign wb_mask  = head.mask;
   assign wb_sca   = head.sca;
   assign wb_w_reg = head.w_reg;

   // Entry storage carries no reset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= in_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else begin
         // DEPTH is a power of two, so pointer wrap is natural overflow.
         if (push_acc) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_acc) - CNT_W'(pop);
         if (push & ~push_acc) overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_valu_wb_fifo.sv
// Purpose : directed self-checking bench for valu_wb_fifo with default parameters.
// Latency : checks are taken 1 time unit after each rising clock edge.
// Backpr. : wb_ready is driven directly to exercise stall, drain and full-with-pop cases.
module tb_valu_wb_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_vec;
   logic [31:0] in_addr;
   logic        in_mask;
   logic        in_sca;
   logic        in_w_reg;
   logic        wb_valid;
   logic        wb_ready;
   logic [63:0] wb_data;
   logic [31:0] wb_addr;
   logic        wb_mask;
   logic        wb_sca;
   logic        wb_w_reg;
   logic        issue_stall;
   logic [4:0]  count;
   logic        overflow_err;

   int n_chk  = 0;
   int n_fail = 0;

   valu_wb_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_vec       (in_vec),
      .in_addr      (in_addr),
      .in_mask      (in_mask),
      .in_sca       (in_sca),
      .in_w_reg     (in_w_reg),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_data      (wb_data),
      .wb_addr      (wb_addr),
      .wb_mask      (wb_mask),
      .wb_sca       (wb_sca),
      .wb_w_reg     (wb_w_reg),
      .issue_stall  (issue_stall),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] vec_of(input logic [31:0] a);
      return {32'hC0DE_0000 ^ a, ~a};
   endfunction

   task automatic drive(input logic v, input logic [31:0] a);
      in_valid = v;
      in_addr  = a;
      in_vec   = vec_of(a);
      in_mask  = a[0];
      in_sca   = a[1];
      in_w_reg = a[2];
   endtask

   initial begin
      rst = 1'b1; wb_ready = 1'b0;
      drive(1'b0, 32'h0);
      tick(); tick();
      rst = 1'b0;

      // Reset state
      chk("rst_count",  count,        0);
      chk("rst_valid",  wb_valid,     0);
      chk("rst_data",   wb_data,      0);
      chk("rst_addr",   wb_addr,      0);
      chk("rst_stall",  issue_stall,  0);
      chk("rst_ovf",    overflow_err, 0);

      // Single push, visible next cycle
      in_valid = 1'b1; in_addr = 32'h10; in_vec = {16{4'hA, 4'h5}};
      in_mask = 1'b1; in_sca = 1'b0; in_w_reg = 1'b0;
      tick();
      drive(1'b0, 32'h0);
      chk("one_valid", wb_valid, 1);
      chk("one_addr",  wb_addr,  32'h10);
      chk("one_data",  wb_data,  64'hA5A5_A5A5_A5A5_A5A5);
      chk("one_mask",  wb_mask,  1);
      chk("one_sca",   wb_sca,   0);
      chk("one_count", count,    1);
      wb_ready = 1'b1;
      tick();
      chk("one_drain_count", count,    0);
      chk("one_drain_valid", wb_valid, 0);
      // Empty with wb_ready=1 must not underflow
      tick();
      chk("empty_ready_count", count, 0);
      wb_ready = 1'b0;

      // Fill 16 with ready low; stall rises once count reaches 9
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'(i));
         tick();
         chk("fill_count", count, 64'(i + 1));
         chk("fill_stall", issue_stall, (i + 1 >= 9) ? 1 : 0);
         chk("fill_hold",  wb_addr, 0);
      end
      drive(1'b0, 32'h0);
      chk("fill_ovf", overflow_err, 0);
      wb_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_valid", wb_valid, 1);
         chk("drain_addr",  wb_addr,  64'(i));
         chk("drain_data",  wb_data,  vec_of(32'(i)));
         chk("drain_flags", {wb_w_reg, wb_sca, wb_mask}, 64'(i % 8));
         tick();
      end
      chk("drain_count", count, 0);
      chk("drain_stall", issue_stall, 0);
      wb_ready = 1'b0;

      // Full: push with pop accepted, push without pop dropped
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'h100 + 32'(i));
         tick();
      end
      chk("full_count", count, 16);
      drive(1'b1, 32'h200); wb_ready = 1'b1;
      tick();
      chk("full_pp_count", count, 16);
      chk("full_pp_ovf",   overflow_err, 0);
      chk("full_pp_head",  wb_addr, 32'h101);
      drive(1'b1, 32'h300); wb_ready = 1'b0;
      tick();
      drive(1'b0, 32'h0);
      chk("full_drop_count", count, 16);
      chk("full_drop_ovf",   overflow_err, 1);
      chk("full_drop_head",  wb_addr, 32'h101);
      wb_ready = 1'b1;
      for (int i = 1; i < 17; i++) begin
         chk("full_drain_addr", wb_addr, (i < 16) ? 64'(32'h100 + 32'(i)) : 64'h200);
         tick();
      end
      chk("full_drain_count", count, 0);
      chk("ovf_sticky", overflow_err, 1);

      // Continuous push+pop with one entry resident, wrapping pointers
      wb_ready = 1'b0;
      drive(1'b1, 32'h0);
      tick();
      wb_ready = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         drive(1'b1, 32'(k));
         tick();
         chk("stream_count", count, 1);
         chk("stream_addr",  wb_addr, 64'(k));
         chk("stream_data",  wb_data, vec_of(32'(k)));
      end
      drive(1'b0, 32'h0);
      tick();
      chk("stream_end_count", count, 0);
      wb_ready = 1'b0;

      // Load 5 then reset mid-operation
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h40 + 32'(i));
         tick();
      end
      drive(1'b0, 32'h0);
      chk("load5_count", count, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_count", count,        0);
      chk("mrst_valid", wb_valid,     0);
      chk("mrst_data",  wb_data,      0);
      chk("mrst_ovf",   overflow_err, 0);
      chk("mrst_stall", issue_stall,  0);
      drive(1'b1, 32'h55);
      tick();
      drive(1'b0, 32'h0);
      chk("post_rst_addr",  wb_addr, 32'h55);
      chk("post_rst_count", count,   1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
